// File: rtl/lvds_pkg.sv
// Shared definitions for the soft LVDS serializer/deserializer link:
// default word width, counter width, RX lock states and the frame-clock window helper.
package lvds_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = $clog2(DATA_W_DEF);

    typedef enum logic {
        RX_HUNT   = 1'b0,
        RX_LOCKED = 1'b1
    } rx_state_e;

    // Frame clock is high for the first half of every frame (bit index 0 .. DATA_W/2-1).
    function automatic logic frame_clk_high(input int unsigned idx, input int unsigned data_w);
        return (idx < (data_w >> 1));
    endfunction

endpackage

// File: rtl/lvds_serdes_link_if.sv
// Parallel/serial signal bundle of the LVDS link; master = user/pad side, slave = link block.
interface lvds_serdes_link_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] tx_in;
    logic              tx_load;
    logic              tx_out;
    logic              tx_outclock;
    logic              rx_in;
    logic              rx_inclock;
    logic [DATA_W-1:0] rx_out;
    logic              rx_valid;
    logic              rx_outclock;
    logic              rx_locked;
    logic              rx_align_err;

    modport master (
        output tx_in,
        output rx_in,
        output rx_inclock,
        input  tx_load,
        input  tx_out,
        input  tx_outclock,
        input  rx_out,
        input  rx_valid,
        input  rx_outclock,
        input  rx_locked,
        input  rx_align_err
    );

    modport slave (
        input  tx_in,
        input  rx_in,
        input  rx_inclock,
        output tx_load,
        output tx_out,
        output tx_outclock,
        output rx_out,
        output rx_valid,
        output rx_outclock,
        output rx_locked,
        output rx_align_err
    );

endinterface

// File: rtl/lvds_deser.sv
// RX path of the LVDS link: retimes serial data and frame clock, aligns on the
// frame-clock rising edge and emits one parallel word per frame.
module lvds_deser
    import lvds_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_data,
    input  logic              rx_frame_clk,
    output logic [DATA_W-1:0] rx_out,
    output logic              rx_valid,
    output logic              rx_outclock,
    output logic              rx_locked,
    output logic              rx_align_err
);

    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    logic              rx_in_q_r;
    logic              ck_q_r;
    logic              ck_qq_r;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] rx_out_r;
    logic [IDX_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  cnt_nxt_s;
    rx_state_e         state_r;
    rx_state_e         state_nxt_s;
    logic              rx_valid_r;
    logic              rx_outclock_r;
    logic              rx_locked_r;
    logic              rx_align_err_r;
    logic              rise_s;
    logic              locked_s;
    logic              word_done_s;
    logic              misalign_s;

    // Input retiming, frame-clock edge history and serial shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_in_q_r <= 1'b0;
            ck_q_r    <= 1'b0;
            ck_qq_r   <= 1'b0;
            shreg_r   <= {DATA_W{1'b0}};
        end else begin
            rx_in_q_r <= rx_data;
            ck_q_r    <= rx_frame_clk;
            ck_qq_r   <= ck_q_r;
            shreg_r   <= {shreg_r[DATA_W-2:0], rx_in_q_r};
        end
    end

    // Lock FSM next state: hunt until the first frame-clock rise, then hold lock
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RX_HUNT: begin
                if (rise_s) begin
                    state_nxt_s = RX_LOCKED;
                end else begin
                    state_nxt_s = RX_HUNT;
                end
            end
            RX_LOCKED: state_nxt_s = RX_LOCKED;
            default:   state_nxt_s = RX_HUNT;
        endcase
    end

    // Bit counter and word-complete / misalignment decode
    always_comb begin
        rise_s    = ck_q_r & ~ck_qq_r;
        locked_s  = (state_r == RX_LOCKED);
        cnt_nxt_s = {IDX_W{1'b0}};
        if (rise_s) begin
            cnt_nxt_s = IDX_W'(1);
        end else if (cnt_r == LAST_IDX) begin
            cnt_nxt_s = {IDX_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + IDX_W'(1);
        end
        // A rise arriving anywhere but the frame boundary drops the partial word
        word_done_s = locked_s && !rise_s && (cnt_r == LAST_IDX);
        misalign_s  = locked_s && rise_s && (cnt_r != {IDX_W{1'b0}});
    end

    // Counter, lock state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r          <= {IDX_W{1'b0}};
            state_r        <= RX_HUNT;
            rx_locked_r    <= 1'b0;
            rx_valid_r     <= 1'b0;
            rx_out_r       <= {DATA_W{1'b0}};
            rx_align_err_r <= 1'b0;
            rx_outclock_r  <= 1'b0;
        end else begin
            cnt_r          <= cnt_nxt_s;
            state_r        <= state_nxt_s;
            rx_locked_r    <= (state_nxt_s == RX_LOCKED);
            rx_valid_r     <= word_done_s;
            rx_align_err_r <= misalign_s;
            rx_outclock_r  <= (cnt_nxt_s != {IDX_W{1'b0}}) &&
                              frame_clk_high(32'(cnt_nxt_s) - 32'd1, 32'(DATA_W));
            if (word_done_s) begin
                rx_out_r <= {shreg_r[DATA_W-2:0], rx_in_q_r};
            end
        end
    end

    assign rx_out       = rx_out_r;
    assign rx_valid     = rx_valid_r;
    assign rx_outclock  = rx_outclock_r;
    assign rx_locked    = rx_locked_r;
    assign rx_align_err = rx_align_err_r;

endmodule

// File: rtl/lvds_serdes_link.sv
// Single-lane soft LVDS link: DATA_W:1 serializer with frame clock plus lvds_deser RX path.
// Optional macro LVDS_INT_LOOPBACK_EN adds loopback_en to feed RX from TX internally.
module lvds_serdes_link
    import lvds_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef LVDS_INT_LOOPBACK_EN
    input  logic               loopback_en,
`endif
    lvds_serdes_link_if.slave  link
);

    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    logic [IDX_W-1:0]  bit_idx_r;
    logic [IDX_W-1:0]  bit_idx_nxt_s;
    logic              capture_s;
    logic [DATA_W-1:0] tx_shreg_r;
    logic              tx_out_r;
    logic              tx_outclock_r;
    logic              tx_load_r;
    logic              rx_data_s;
    logic              rx_frame_clk_s;

    // TX bit index sequencing; the wrap to 0 is the capture edge
    always_comb begin
        capture_s     = 1'b0;
        bit_idx_nxt_s = {IDX_W{1'b0}};
        if (bit_idx_r == LAST_IDX) begin
            capture_s     = 1'b1;
            bit_idx_nxt_s = {IDX_W{1'b0}};
        end else begin
            capture_s     = 1'b0;
            bit_idx_nxt_s = bit_idx_r + IDX_W'(1);
        end
    end

    // TX shift register, serial output and frame-clock / load strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_r     <= LAST_IDX;
            tx_shreg_r    <= {DATA_W{1'b0}};
            tx_out_r      <= 1'b0;
            tx_outclock_r <= 1'b0;
            tx_load_r     <= 1'b1;
        end else begin
            bit_idx_r     <= bit_idx_nxt_s;
            tx_outclock_r <= frame_clk_high(32'(bit_idx_nxt_s), 32'(DATA_W));
            tx_load_r     <= (bit_idx_nxt_s == LAST_IDX);
            if (capture_s) begin
                tx_shreg_r <= link.tx_in;
                tx_out_r   <= link.tx_in[DATA_W-1];
            end else begin
                // tx_out is the register's next MSB, so it stays in step with the shift
                tx_shreg_r <= {tx_shreg_r[DATA_W-2:0], 1'b0};
                tx_out_r   <= tx_shreg_r[DATA_W-2];
            end
        end
    end

`ifdef LVDS_INT_LOOPBACK_EN
    assign rx_data_s      = loopback_en ? tx_out_r      : link.rx_in;
    assign rx_frame_clk_s = loopback_en ? tx_outclock_r : link.rx_inclock;
`else
    assign rx_data_s      = link.rx_in;
    assign rx_frame_clk_s = link.rx_inclock;
`endif

    lvds_deser #(
        .DATA_W (DATA_W)
    ) u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data_s),
        .rx_frame_clk (rx_frame_clk_s),
        .rx_out       (link.rx_out),
        .rx_valid     (link.rx_valid),
        .rx_outclock  (link.rx_outclock),
        .rx_locked    (link.rx_locked),
        .rx_align_err (link.rx_align_err)
    );

    assign link.tx_out      = tx_out_r;
    assign link.tx_outclock = tx_outclock_r;
    assign link.tx_load     = tx_load_r;

endmodule

// File: tb/tb_lvds_serdes_link.sv
// Directed bench for lvds_serdes_link: TX framing, external loopback, mid-frame tx_in change,
// RX lane skew step, asynchronous mid-frame reset and (with LVDS_INT_LOOPBACK_EN) internal loopback.
module tb_lvds_serdes_link;

    localparam int W = 8;

    logic clk;
    logic rst_n;
`ifdef LVDS_INT_LOOPBACK_EN
    logic loopback_en;
`endif

    lvds_serdes_link_if #(.DATA_W(W)) lk ();

    lvds_serdes_link #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef LVDS_INT_LOOPBACK_EN
        .loopback_en (loopback_en),
`endif
        .link        (lk)
    );

    int         n_cmp;
    int         n_err;
    int         cyc;
    int         dly;
    int         err_cnt;
    int         err_cyc;
    logic       arm_skew;
    logic       ext_zero;
    logic [3:0] h_out;
    logic [3:0] h_ck;
    logic [7:0] so_v;
    logic [7:0] ck_v;
    logic [7:0] ld_v;
    logic [5:0] mid_v;

    // Free-running bit clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample after the edge, then drive the RX lane from the TX history (skewable)
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        h_out = {h_out[2:0], lk.tx_out};
        h_ck  = {h_ck[2:0], lk.tx_outclock};
        if (arm_skew && h_ck[0] && !h_ck[1]) begin
            dly      = 3;
            arm_skew = 1'b0;
        end
        if (ext_zero) begin
            lk.rx_in      = 1'b0;
            lk.rx_inclock = 1'b0;
        end else begin
            lk.rx_in      = h_out[dly];
            lk.rx_inclock = h_ck[dly];
        end
        if (lk.rx_align_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    endtask

    task automatic wait_valid(input string tag, input int budget, input int exp_cyc,
                              input logic [7:0] exp_word);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!lk.rx_valid && n < budget);
        check_eq({tag, "_seen"}, 32'(lk.rx_valid), 32'd1);
        check_eq({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_word"}, 32'(lk.rx_out), 32'(exp_word));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; dly = 0; err_cnt = 0; err_cyc = 0;
        arm_skew = 1'b0; ext_zero = 1'b0; h_out = 4'h0; h_ck = 4'h0;
        so_v = 8'h00; ck_v = 8'h00; ld_v = 8'h00; mid_v = 6'h00;
        rst_n = 1'b1;
        lk.tx_in = 8'h11; lk.rx_in = 1'b0; lk.rx_inclock = 1'b0;
`ifdef LVDS_INT_LOOPBACK_EN
        loopback_en = 1'b0;
`endif
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_tx_out",      32'(lk.tx_out),       32'd0);
        check_eq("rst_tx_outclock", 32'(lk.tx_outclock),  32'd0);
        check_eq("rst_tx_load",     32'(lk.tx_load),      32'd1);
        check_eq("rst_rx_out",      32'(lk.rx_out),       32'd0);
        check_eq("rst_rx_valid",    32'(lk.rx_valid),     32'd0);
        check_eq("rst_rx_outclock", 32'(lk.rx_outclock),  32'd0);
        check_eq("rst_rx_locked",   32'(lk.rx_locked),    32'd0);
        check_eq("rst_rx_align",    32'(lk.rx_align_err), 32'd0);
        rst_n = 1'b1;

        // First frame of 8'h11, MSB first; edge 1 is the capture edge
        for (int k = 0; k < 8; k++) begin
            step();
            so_v = {so_v[6:0], lk.tx_out};
            ck_v = {ck_v[6:0], lk.tx_outclock};
            ld_v = {ld_v[6:0], lk.tx_load};
        end
        check_eq("tx_bits",  32'(so_v), 32'h11);
        check_eq("tx_clock", 32'(ck_v), 32'hF0);
        check_eq("tx_load",  32'(ld_v), 32'h01);

        // Word captured at edge 1 arrives after edge 1+8+1
        wait_valid("lb_w0", 20, 10, 8'h11);
        check_eq("locked", 32'(lk.rx_locked), 32'd1);

        // Change tx_in mid-frame: remaining bits 5..0 of 8'h11 must be unaffected
        lk.tx_in = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            step();
            mid_v = {mid_v[4:0], lk.tx_out};
        end
        check_eq("mid_frame_bits", 32'(mid_v), 32'h11);
        wait_valid("lb_w1", 20, 18, 8'h11);
        wait_valid("lb_w2", 20, 26, 8'hFF);

        // Skew the whole RX lane by 3 clocks starting at the capture edge 33
        lk.tx_in = 8'h3C;
        arm_skew = 1'b1;
        wait_valid("sk_w3", 20, 34, 8'hFF);
        check_eq("sk_err_none", 32'(err_cnt), 32'd0);
        wait_valid("sk_w4", 20, 45, 8'h3C);
        check_eq("sk_err_cnt", 32'(err_cnt), 32'd1);
        check_eq("sk_err_cyc", 32'(err_cyc), 32'd38);
        wait_valid("sk_w5", 20, 53, 8'h3C);
        check_eq("sk_err_once", 32'(err_cnt), 32'd1);

        // Asynchronous reset in the middle of a frame
        step(); step(); step();
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_flags", 32'({lk.tx_out, lk.tx_outclock, lk.tx_load, lk.rx_valid,
                                    lk.rx_outclock, lk.rx_locked, lk.rx_align_err}), 32'h10);
        check_eq("arst_rx_out", 32'(lk.rx_out), 32'd0);
        @(negedge clk);
        dly = 0; h_out = 4'h0; h_ck = 4'h0; cyc = 0; err_cnt = 0;
        lk.rx_in = 1'b0; lk.rx_inclock = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
        end
        check_eq("relock_rx_out0", 32'(lk.rx_out), 32'd0);
        wait_valid("relock_w0", 20, 10, 8'h3C);
        check_eq("relock_err", 32'(err_cnt), 32'd0);

`ifdef LVDS_INT_LOOPBACK_EN
        // Internal loopback with the external pins held low
        ext_zero    = 1'b1;
        loopback_en = 1'b1;
        lk.tx_in    = 8'hA5;
        wait_valid("int_w0", 20, 18, 8'h3C);
        wait_valid("int_w1", 20, 26, 8'hA5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
